pemstat_sacc_mc: RTL and testbench
==================================

// Module: pemstat_sacc_mc
// PURPOSE
//  Multi-channel statistics accumulator for the MAC statistics block. NCH counters of CNT_W bits,
//  each advanced by an INC_W-bit increment. Supports host load, host read with optional clear-on-read,
//  wrap or saturate mode, and sticky per-channel overflow flags with an aggregate interrupt.
//  Successor to the single-channel 12-bit stat adder; sits between the MAC event decoders and the host register bank.
// PARAMETERS
//  NCH    8   number of counter channels (2..32)
//  CNT_W  32  counter width in bits (8..32)
//  INC_W  4   increment width in bits (1..8, < CNT_W)
//  CH_W   $clog2(NCH)  channel index width (derived, localparam)
// PORTS
//  clk        in   1      single clock; all logic on posedge
//  rst_n      in   1      synchronous active-low reset
//  inc_vld    in   1      increment request this cycle
//  inc_ch     in   CH_W   channel to increment
//  inc_val    in   INC_W  increment amount (0 allowed)
//  wr_en      in   1      host load strobe
//  wr_ch      in   CH_W   channel to load
//  wr_data    in   32     load value; bits [CNT_W-1:0] used
//  rd_en      in   1      host read strobe
//  rd_ch      in   CH_W   channel to read
//  rd_data    out  32     read data, counter zero-extended
//  rd_vld     out  1      rd_data valid (one-cycle pulse)
//  cor_en     in   1      1 = clear-on-read
//  sat_mode   in   1      1 = saturate at all-ones; 0 = wrap
//  ovf_clr    in   NCH    write-1-to-clear mask for overflow flags
//  ovf_flags  out  NCH    sticky per-channel overflow flags
//  ovf_irq    out  1      registered OR of ovf_flags
// BEHAVIOUR
//  - Reset (rst_n=0 at a posedge): all counters 0, ovf_flags 0, rd_data 0, rd_vld 0, ovf_irq 0.
//  - Sum = cnt[ch] + zero-extended inc_val, computed CNT_W+1 wide; carry = sum[CNT_W].
//  - Wrap mode: cnt <= sum[CNT_W-1:0]. Saturate mode: on carry, cnt <= all-ones and holds.
//  - Every carry (either mode) sets ovf_flags[ch]. ovf_clr[ch] has priority over a same-cycle set.
//  - Read: rd_en captures cnt[rd_ch] as it stands BEFORE this cycle's update. rd_data/rd_vld are valid
//    the next cycle (latency 1). rd_data holds its value until the next read.
//  - Per-channel update priority, highest first:
//      1 wr_en & wr_ch==ch         -> cnt <= wr_data[CNT_W-1:0]; a same-channel inc is dropped
//      2 rd clear & inc same ch    -> cnt <= inc_val (clear then add; carry impossible)
//      3 inc_vld & inc_ch==ch      -> sum rule above
//      4 rd_en & cor_en & rd_ch==ch -> cnt <= 0
//      5 otherwise hold
//  - Different channels update independently in the same cycle.
//  - Write and read to the same channel in one cycle: read returns the old value; write wins the update.
//  - ovf_irq is registered: it lags ovf_flags by one cycle.
//  - Out-of-range channel index (>= NCH): access is ignored, and rd_data returns 0 with rd_vld=1.
// CONFIGURATION
//  PEMSTAT_SACC_SNAP_EN defined: adds input snap (1 bit) and an NCH x CNT_W shadow array.
//    snap=1 copies all counters, post-update for that cycle, into the shadow array.
//    Reads return shadow values. cor_en clears the live counter, not the shadow.
//    The shadow resets to 0.
//  Macro undefined: no snap port, no shadow array; reads return live counters as specified above.
// STRUCTURE
//  pemstat_pkg: localparam defaults (NCH, CNT_W, INC_W) and the priority encoding, shared with the
//    register bank.
//  Sub-module pemstat_sacc_lane: one per channel, holds the counter and overflow flag, implements the
//    priority, wrap and saturate rules. It is generated NCH times.
//  The top level decodes channel indices and muxes read data.
// TESTING
//  1 Reset, then inc ch3 by 5, three times; read ch3 -> rd_data=15 one cycle later, rd_vld pulses.
//  2 CNT_W=8, wrap mode: load ch0=0xFE, inc 3 -> cnt=0x01 and ovf_flags[0]=1; ovf_irq=1 one cycle later.
//  3 Saturate mode: load ch1=0xFD, inc 7 -> cnt=0xFF, flag set. A further inc 1 keeps 0xFF.
//  4 cor_en=1, ch2=40: read ch2 while inc ch2 by 2 in the same cycle -> rd_data=40, cnt=2.
//    Then ovf_clr[2] and a carry in the same cycle -> flag remains 0.
//  5 Same cycle: wr ch4=100, inc ch4 by 9, read ch4 (old value 7) -> rd_data=7, cnt=100.
//    Then assert rst_n=0 mid-sequence -> all counters, flags and outputs return to 0.
//  6 With SNAP_EN: ch5=10, snap, inc ch5 by 4, read ch5 -> rd_data=10, live counter=14.

Source files
------------

// File: rtl/pemstat_pkg.sv
// Shared definitions for the MAC statistics accumulator and the host register bank.
// Default counter geometry and the per-lane update priority encoding live here.
package pemstat_pkg;

  localparam int unsigned NchDef  = 8;
  localparam int unsigned CntWDef = 32;
  localparam int unsigned IncWDef = 4;

  // Per-lane update operation, resolved from the three per-lane request hits.
  typedef enum logic [2:0] {
    OpHold,
    OpClear,
    OpInc,
    OpClrInc,
    OpLoad
  } lane_op_e;

  // Priority: host load > clear-then-add > increment > clear-on-read > hold.
  function automatic lane_op_e lane_op(logic wr_hit, logic inc_hit, logic clr_hit);
    if (wr_hit) begin
      return OpLoad;
    end else if (clr_hit && inc_hit) begin
      return OpClrInc;
    end else if (inc_hit) begin
      return OpInc;
    end else if (clr_hit) begin
      return OpClear;
    end
    return OpHold;
  endfunction

endpackage

// File: rtl/pemstat_sacc_lane.sv
// One statistics counter channel: counter register plus sticky overflow flag.
// Applies the load / clear / increment priority and the wrap or saturate rule.
module pemstat_sacc_lane
  import pemstat_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned INC_W = IncWDef
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_hit_i,
  input  logic [CNT_W-1:0] wr_data_i,
  input  logic             inc_hit_i,
  input  logic [INC_W-1:0] inc_val_i,
  input  logic             clr_hit_i,
  input  logic             sat_mode_i,
  input  logic             ovf_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cnt_d_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W:0]   sum;
  logic             carry;
  lane_op_e         op;

  assign sum = {1'b0, cnt_q} + (CNT_W + 1)'(inc_val_i);
  assign op  = lane_op(wr_hit_i, inc_hit_i, clr_hit_i);

  // Next counter value and overflow flag; only a plain increment can carry.
  always_comb begin
    cnt_d = cnt_q;
    carry = 1'b0;
    unique case (op)
      OpLoad:   cnt_d = wr_data_i;
      OpClrInc: cnt_d = CNT_W'(inc_val_i);
      OpInc: begin
        carry = sum[CNT_W];
        cnt_d = (carry && sat_mode_i) ? '1 : sum[CNT_W-1:0];
      end
      OpClear:  cnt_d = '0;
      default:  cnt_d = cnt_q;
    endcase
    // Host clear wins over a same-cycle overflow.
    ovf_d = ovf_clr_i ? 1'b0 : (ovf_q | carry);
  end

  // Counter and flag state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/pemstat_sacc_mc.sv
// Multi-channel statistics accumulator: NCH counter lanes, host load/read with optional
// clear-on-read, sticky overflow flags and a registered aggregate interrupt.
// Optional build macro PEMSTAT_SACC_SNAP_EN adds a snap input and a shadow array that reads use.
module pemstat_sacc_mc
  import pemstat_pkg::*;
#(
  parameter int unsigned NCH   = NchDef,
  parameter int unsigned CNT_W = CntWDef,
  parameter int unsigned INC_W = IncWDef,
  localparam int unsigned CH_W = $clog2(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_vld_i,
  input  logic [CH_W-1:0]  inc_ch_i,
  input  logic [INC_W-1:0] inc_val_i,
  input  logic             wr_en_i,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [31:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [CH_W-1:0]  rd_ch_i,
`ifdef PEMSTAT_SACC_SNAP_EN
  input  logic             snap_i,
`endif
  output logic [31:0]      rd_data_o,
  output logic             rd_vld_o,
  input  logic             cor_en_i,
  input  logic             sat_mode_i,
  input  logic [NCH-1:0]   ovf_clr_i,
  output logic [NCH-1:0]   ovf_flags_o,
  output logic             ovf_irq_o
);

  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];
  logic [CNT_W-1:0] rd_src [NCH];
  logic [CNT_W-1:0] rd_sel;
  logic [31:0]      rd_data_q;
  logic             rd_vld_q;
  logic             ovf_irq_q;

  if (CNT_W < 32) begin : g_wr_unused
    logic unused_wr_hi;
    assign unused_wr_hi = ^wr_data_i[31:CNT_W];
  end

  // Out-of-range channel indices match no lane, so such accesses fall through untouched.
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    pemstat_sacc_lane #(
      .CNT_W (CNT_W),
      .INC_W (INC_W)
    ) u_lane (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .wr_hit_i   (wr_en_i && (wr_ch_i == CH_W'(i))),
      .wr_data_i  (wr_data_i[CNT_W-1:0]),
      .inc_hit_i  (inc_vld_i && (inc_ch_i == CH_W'(i))),
      .inc_val_i  (inc_val_i),
      .clr_hit_i  (rd_en_i && cor_en_i && (rd_ch_i == CH_W'(i))),
      .sat_mode_i (sat_mode_i),
      .ovf_clr_i  (ovf_clr_i[i]),
      .cnt_o      (cnt_q[i]),
      .cnt_d_o    (cnt_d[i]),
      .ovf_o      (ovf_flags_o[i])
    );
  end

`ifdef PEMSTAT_SACC_SNAP_EN
  logic [CNT_W-1:0] shadow_q [NCH];

  // Snapshot captures the post-update counters; clear-on-read never touches the shadow.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!rst_ni) begin
        shadow_q[i] <= '0;
      end else if (snap_i) begin
        shadow_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_src = shadow_q;
`else
  logic [CNT_W-1:0] unused_cnt_d [NCH];
  assign unused_cnt_d = cnt_d;
  assign rd_src       = cnt_q;
`endif

  // Read mux; an out-of-range channel selects nothing and yields zero.
  always_comb begin
    rd_sel = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        rd_sel = rd_src[i];
      end
    end
  end

  // Read data register (held between reads), read-valid pulse and aggregate interrupt.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
      ovf_irq_q <= 1'b0;
    end else begin
      rd_vld_q  <= rd_en_i;
      ovf_irq_q <= |ovf_flags_o;
      if (rd_en_i) begin
        rd_data_q <= 32'(rd_sel);
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_vld_o  = rd_vld_q;
  assign ovf_irq_o = ovf_irq_q;

endmodule

// File: tb/tb_pemstat_sacc_mc.sv
// Directed bench for pemstat_sacc_mc (NCH=6 so indices 6/7 are out of range, CNT_W=8).
// Reads push expected data and due cycle into a queue; a monitor pops on rd_vld.
module tb_pemstat_sacc_mc;
  localparam int unsigned NCH   = 6;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned INC_W = 4;
  localparam int unsigned CH_W  = $clog2(NCH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             inc_vld;
  logic [CH_W-1:0]  inc_ch;
  logic [INC_W-1:0] inc_val;
  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [31:0]      wr_data;
  logic             rd_en;
  logic [CH_W-1:0]  rd_ch;
  logic             snap;
  logic [31:0]      rd_data;
  logic             rd_vld;
  logic             cor_en;
  logic             sat_mode;
  logic [NCH-1:0]   ovf_clr;
  logic [NCH-1:0]   ovf_flags;
  logic             ovf_irq;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pemstat_sacc_mc #(
    .NCH   (NCH),
    .CNT_W (CNT_W),
    .INC_W (INC_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inc_vld_i   (inc_vld),
    .inc_ch_i    (inc_ch),
    .inc_val_i   (inc_val),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_data_i   (wr_data),
    .rd_en_i     (rd_en),
    .rd_ch_i     (rd_ch),
`ifdef PEMSTAT_SACC_SNAP_EN
    .snap_i      (snap),
`endif
    .rd_data_o   (rd_data),
    .rd_vld_o    (rd_vld),
    .cor_en_i    (cor_en),
    .sat_mode_i  (sat_mode),
    .ovf_clr_i   (ovf_clr),
    .ovf_flags_o (ovf_flags),
    .ovf_irq_o   (ovf_irq)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rd_vld pulse must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    if (rd_vld === 1'b1) begin
      if (q.size() == 0) begin
        chk("rd_vld_unexpected", 32'(rd_vld), 32'd0);
      end else begin
        chk("rd_data", rd_data, q[0].data);
        chk("rd_latency", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      chk("rd_vld_missing", 32'(rd_vld), 32'd1);
      void'(q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    inc_vld = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = '0;
  endtask

  task automatic wr(input int ch, input logic [31:0] val);
    wr_en   = 1'b1;
    wr_ch   = CH_W'(ch);
    wr_data = val;
  endtask

  task automatic inc(input int ch, input int val);
    inc_vld = 1'b1;
    inc_ch  = CH_W'(ch);
    inc_val = INC_W'(val);
  endtask

  task automatic rd(input int ch, input logic [31:0] exp);
    rd_en = 1'b1;
    rd_ch = CH_W'(ch);
    q.push_back('{data: exp, due: cyc + 1});
  endtask

  initial begin
    rst_n    = 1'b0;
    inc_vld  = 1'b0;
    inc_ch   = '0;
    inc_val  = '0;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_data  = '0;
    rd_en    = 1'b0;
    rd_ch    = '0;
    snap     = 1'b1;  // continuous snapshot makes shadow reads track the live counters
    cor_en   = 1'b0;
    sat_mode = 1'b0;
    ovf_clr  = '0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("rst_flags", 32'(ovf_flags), 32'd0);
    chk("rst_irq", 32'(ovf_irq), 32'd0);

    // Three increments of 5, then read 15.
    for (int i = 0; i < 3; i++) begin
      inc(3, 5);
      tick();
    end
    rd(3, 32'd15);
    tick();

    // Wrap: 0xFE + 3 = 0x01 with overflow; irq one cycle later.
    wr(0, 32'hFE);
    tick();
    inc(0, 3);
    tick();
    chk("wrap_flag0", 32'(ovf_flags[0]), 32'd1);
    chk("wrap_irq_lag", 32'(ovf_irq), 32'd0);
    tick();
    chk("wrap_irq", 32'(ovf_irq), 32'd1);
    rd(0, 32'h01);
    tick();

    // Saturate: 0xFD + 7 sticks at 0xFF, a further +1 holds.
    sat_mode = 1'b1;
    wr(1, 32'hFD);
    tick();
    inc(1, 7);
    tick();
    chk("sat_flag1", 32'(ovf_flags[1]), 32'd1);
    inc(1, 1);
    tick();
    rd(1, 32'hFF);
    tick();
    sat_mode = 1'b0;

    // Write-1-to-clear all flags; irq follows a cycle later.
    ovf_clr = '1;
    tick();
    chk("clr_flags", 32'(ovf_flags), 32'd0);
    tick();
    chk("clr_irq", 32'(ovf_irq), 32'd0);

    // Clear-on-read with same-cycle increment: old value returned, counter = inc.
    wr(2, 32'd40);
    tick();
    cor_en = 1'b1;
    rd(2, 32'd40);
    inc(2, 2);
    tick();
    cor_en = 1'b0;
    rd(2, 32'd2);
    tick();
    // Flag clear beats a same-cycle carry.
    wr(2, 32'hFF);
    tick();
    inc(2, 1);
    ovf_clr = NCH'(6'b000100);
    tick();
    chk("clr_beats_set", 32'(ovf_flags[2]), 32'd0);
    rd(2, 32'd0);
    tick();

    // Plain clear-on-read.
    cor_en = 1'b1;
    rd(3, 32'd15);
    tick();
    cor_en = 1'b0;
    rd(3, 32'd0);
    tick();

    // Write, increment and read the same channel in one cycle.
    wr(4, 32'd7);
    tick();
    wr(4, 32'd100);
    inc(4, 9);
    rd(4, 32'd7);
    tick();
    rd(4, 32'd100);
    tick();

    // Independent channels in one cycle, back-to-back reads, zero increment.
    wr(0, 32'd20);
    inc(3, 2);
    rd(4, 32'd100);
    tick();
    inc(3, 0);
    rd(0, 32'd20);
    tick();
    rd(3, 32'd2);
    tick();

    // Out-of-range channels: ignored, read returns 0 with valid.
    wr(7, 32'd50);
    inc(6, 3);
    rd(7, 32'd0);
    tick();
    rd(6, 32'd0);
    tick();

    // Raise a flag, leave rd_data nonzero, then reset mid-sequence.
    wr(5, 32'hFF);
    tick();
    inc(5, 1);
    tick();
    rd(4, 32'd100);
    tick();
    chk("pre_rst_flag5", 32'(ovf_flags[5]), 32'd1);
    chk("pre_rst_irq", 32'(ovf_irq), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_rd_data", rd_data, 32'd0);
    chk("mid_rst_rd_vld", 32'(rd_vld), 32'd0);
    chk("mid_rst_flags", 32'(ovf_flags), 32'd0);
    chk("mid_rst_irq", 32'(ovf_irq), 32'd0);
    rd(4, 32'd0);
    tick();
    rd(0, 32'd0);
    tick();

`ifdef PEMSTAT_SACC_SNAP_EN
    // Snapshot: read sees the frozen shadow, not the live increment.
    wr(5, 32'd10);
    tick();
    snap = 1'b0;
    inc(5, 4);
    tick();
    rd(5, 32'd10);
    tick();
    snap = 1'b1;
    tick();
    rd(5, 32'd14);
    tick();
`endif

    tick();
    tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
